// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package countdown_timer_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/full_cla.sv
// Parallel-prefix carry-lookahead adder: sum = operandA + operandB + carryin.
// Purely combinational; carryout is the carry out of the MSB.
module full_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             carryin,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] gl [LEVELS+1];
  logic [WIDTH-1:0] pl [LEVELS+1];
  logic [WIDTH:0]   carry;

  assign gl[0] = operandA & operandB;
  assign pl[0] = operandA ^ operandB;

  // Kogge-Stone prefix tree: level l combines spans of 2**l bits.
  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_comb
        assign gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
        assign pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        assign pl[l+1][i] = pl[l][i];
      end
    end
  end

  assign carry    = {gl[LEVELS] | (pl[LEVELS] & {WIDTH{carryin}}), carryin};
  assign sum      = pl[0] ^ carry[WIDTH-1:0];
  assign carryout = carry[WIDTH];

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle done pulse and optional auto-reload.
// done rises N clocks after a start with load_value=N while enable is held high.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] dec_sum;
  logic             dec_cout;
  logic             cnt_is_one;

  // count + all-ones == count - 1; carry out is set whenever count != 0.
  full_cla #(.WIDTH(WIDTH)) count_dec (
    .operandA (count_q),
    .operandB ({WIDTH{1'b1}}),
    .carryin  (1'b0),
    .sum      (dec_sum),
    .carryout (dec_cout)
  );

  assign cnt_is_one = dec_cout && (dec_sum == '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;

    if (start) begin
      if (load_value != '0) begin
        count_d  = load_value;
        reload_d = load_value;
        mode_d   = auto_reload;
        state_d  = RUN;
      end else begin
        count_d = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == RUN) begin
      if (stop) begin
        state_d = IDLE;
      end else if (enable) begin
        if (cnt_is_one) begin
          done_d = 1'b1;
          if (mode_q) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else begin
          count_d = dec_sum;
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer with an expected-value queue per clock.
module tb_countdown_timer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic         start;
    logic         stop;
    logic         enable;
    logic         auto_reload;
    logic [W-1:0] load_value;
    logic [W-1:0] exp_count;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  countdown_timer #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .enable      (enable),
    .auto_reload (auto_reload),
    .load_value  (load_value),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic st, input logic sp, input logic en,
                     input logic ar, input logic [W-1:0] lv, input logic [W-1:0] ec,
                     input logic eb, input logic ed);
    vec_t v;
    v.name = name; v.start = st; v.stop = sp; v.enable = en; v.auto_reload = ar;
    v.load_value = lv; v.exp_count = ec; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  // Drive one vector for one clock edge, then compare the outputs it produced.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clock);
    start = v.start; stop = v.stop; enable = v.enable;
    auto_reload = v.auto_reload; load_value = v.load_value;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      check({e.name, ".count"}, count, e.exp_count);
      check({e.name, ".busy"}, {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, e.exp_busy});
      check({e.name, ".done"}, {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, e.exp_done});
    end
  endtask

  initial begin
    //    name        st sp en ar load          count         busy done
    add("post_rst",   0, 0, 0, 0, 0,            0,            0, 0);
    // one-shot 5
    add("os_start",   1, 0, 1, 0, 5,            5,            1, 0);
    add("os_4",       0, 0, 1, 0, 0,            4,            1, 0);
    add("os_3",       0, 0, 1, 0, 0,            3,            1, 0);
    add("os_2",       0, 0, 1, 0, 0,            2,            1, 0);
    add("os_1",       0, 0, 1, 0, 0,            1,            1, 0);
    add("os_0",       0, 0, 1, 0, 0,            0,            0, 1);
    add("os_after",   0, 0, 1, 0, 0,            0,            0, 0);
    add("idle_stop",  0, 1, 0, 0, 0,            0,            0, 0);
    // auto-reload 3, 12 enabled cycles
    add("ar_start",   1, 0, 1, 1, 3,            3,            1, 0);
    for (int k = 0; k < 4; k++) begin
      add("ar_2",     0, 0, 1, 0, 0,            2,            1, 0);
      add("ar_1",     0, 0, 1, 0, 0,            1,            1, 0);
      add("ar_rld",   0, 0, 1, 0, 0,            3,            1, 1);
    end
    add("ar_stop",    0, 1, 1, 0, 0,            3,            0, 0);
    // auto-reload with period 1
    add("ar1_start",  1, 0, 1, 1, 1,            1,            1, 0);
    add("ar1_p1",     0, 0, 1, 0, 0,            1,            1, 1);
    add("ar1_p2",     0, 0, 1, 0, 0,            1,            1, 1);
    add("ar1_stop",   0, 1, 0, 0, 0,            1,            0, 0);
    // enable gating then stop
    add("en_start",   1, 0, 1, 0, 4,            4,            1, 0);
    add("en_1",       0, 0, 1, 0, 0,            3,            1, 0);
    add("en_0",       0, 0, 0, 0, 0,            3,            1, 0);
    add("en_1b",      0, 0, 1, 0, 0,            2,            1, 0);
    add("en_0b",      0, 0, 0, 0, 0,            2,            1, 0);
    add("en_stop",    0, 1, 1, 0, 0,            2,            0, 0);
    add("idle_en",    0, 0, 1, 0, 0,            2,            0, 0);
    // restart priority
    add("rs_start",   1, 0, 1, 0, 10,           10,           1, 0);
    add("rs_9",       0, 0, 1, 0, 0,            9,            1, 0);
    add("rs_8",       0, 0, 1, 0, 0,            8,            1, 0);
    add("rs_7",       0, 0, 1, 0, 0,            7,            1, 0);
    add("rs_prio",    1, 1, 1, 0, 20,           20,           1, 0);
    add("rs_hold",    0, 0, 0, 0, 0,            20,           1, 0);
    add("rs_zero",    1, 0, 1, 0, 0,            0,            0, 1);
    add("rs_after",   0, 0, 1, 0, 0,            0,            0, 0);
    // width boundary
    add("wb_start",   1, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    add("wb_1",       0, 0, 1, 0, 0,            32'hFFFFFFFE, 1, 0);
    add("wb_2",       0, 0, 1, 0, 0,            32'hFFFFFFFD, 1, 0);
    add("wb_stop",    0, 1, 0, 0, 0,            32'hFFFFFFFD, 0, 0);

    // Reset asserted at time 0
    #2;
    check("rst0.count", count, '0);
    check("rst0.busy", {{(W-1){1'b0}}, busy}, '0);
    check("rst0.done", {{(W-1){1'b0}}, done}, '0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-run: asynchronous, between edges
    begin
      vec_t v;
      v.name = "mr_start"; v.start = 1; v.stop = 0; v.enable = 1; v.auto_reload = 0;
      v.load_value = 10; v.exp_count = 10; v.exp_busy = 1; v.exp_done = 0;
      apply(v);
      for (int k = 1; k <= 3; k++) begin
        v.name = "mr_run"; v.start = 0; v.load_value = 0;
        v.exp_count = 10 - k;
        apply(v);
      end
      #2;
      reset = 1'b0;
      #1;
      check("mr_async.count", count, '0);
      check("mr_async.busy", {{(W-1){1'b0}}, busy}, '0);
      check("mr_async.done", {{(W-1){1'b0}}, done}, '0);
      @(posedge clock);
      @(negedge clock);
      enable = 1'b0;
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
        v.name = "mr_release"; v.start = 0; v.enable = 0;
        v.exp_count = 0; v.exp_busy = 0; v.exp_done = 0;
        apply(v);
      end
    end

    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
